// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: turns one "roll N dice of S sides" request into N RNG runs,
// reducing each 16-bit RNG result mod S by restoring division and summing the faces.
module dice_roll_ctrl #(
  parameter int NDICE_W = 4,
  parameter int SIDES_W = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_i,
  input  logic [NDICE_W-1:0]         num_dice_i,
  input  logic [SIDES_W-1:0]         sides_i,
  output logic                       busy_o,
  output logic                       rng_start_o,
  input  logic [31:0]                rng_result_i,
  input  logic                       rng_done_i,
  output logic [SIDES_W-1:0]         face_o,
  output logic                       face_valid_o,
  output logic [NDICE_W+SIDES_W-1:0] total_o,
  output logic                       done_o,
  output logic                       error_o
);
  localparam int TOTAL_W = NDICE_W + SIDES_W;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, REDUCE, ACCUM, FINISH} state_t;
  state_t              state_q, state_d;
  logic [NDICE_W-1:0]  num_q, num_d, left_q, left_d;
  logic [SIDES_W-1:0]  sides_q, sides_d, face_q, face_d;
  logic [15:0]         dvd_q, dvd_d;
  logic [SIDES_W:0]    rem_q, rem_d;
  logic [3:0]          step_q, step_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic                fv_q, fv_d, err_q, err_d;
  logic [SIDES_W:0]    trial;
  logic [SIDES_W-1:0]  face_nx;
  logic                unused_hi;
  assign unused_hi = ^rng_result_i[31:16];
  // one restoring-division step: shift in the next dividend bit, subtract S if it fits
  assign trial   = {rem_q[SIDES_W-1:0], dvd_q[15]};
  assign face_nx = rem_q[SIDES_W-1:0] + SIDES_W'(1);
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    left_d  = left_q;
    sides_d = sides_q;
    face_d  = face_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    total_d = total_q;
    fv_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_i) begin
        num_d   = num_dice_i;
        sides_d = sides_i;
        total_d = '0;
        err_d   = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        err_d   = (num_q == '0) || (sides_q < SIDES_W'(2));
        left_d  = num_q;
        state_d = err_d ? FINISH : ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (rng_done_i) begin
        dvd_d   = rng_result_i[15:0];
        rem_d   = '0;
        step_d  = '0;
        state_d = REDUCE;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = FINISH;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
      REDUCE: begin
        rem_d   = (trial >= {1'b0, sides_q}) ? trial - {1'b0, sides_q} : trial;
        dvd_d   = {dvd_q[14:0], 1'b0};
        step_d  = step_q + 4'd1;
        state_d = (step_q == 4'd15) ? ACCUM : REDUCE;
      end
      ACCUM: begin
        face_d  = face_nx;
        fv_d    = 1'b1;
        total_d = total_q + {{NDICE_W{1'b0}}, face_nx};
        left_d  = left_q - NDICE_W'(1);
        state_d = (left_q == NDICE_W'(1)) ? FINISH : ISSUE;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      left_q  <= '0;
      sides_q <= '0;
      face_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      tmo_q   <= '0;
      total_q <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      left_q  <= left_d;
      sides_q <= sides_d;
      face_q  <= face_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      total_q <= total_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end
  // face_valid is registered so it rises together with the new face and total
  assign busy_o       = state_q != IDLE;
  assign rng_start_o  = state_q == ISSUE;
  assign done_o       = state_q == FINISH;
  assign error_o      = done_o && err_q;
  assign face_o       = face_q;
  assign face_valid_o = fv_q;
  assign total_o      = total_q;
endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb_dice_roll_ctrl: directed bench for dice_roll_ctrl with a scripted RNG model
// (programmable done delay, result table, or no done at all).
module tb_dice_roll_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_i = 1'b0;
  logic [3:0]  num_dice_i = '0;
  logic [7:0]  sides_i = '0;
  logic        busy_o, rng_start_o, face_valid_o, done_o, error_o;
  logic [31:0] rng_result_i = '0;
  logic        rng_done_i = 1'b0;
  logic [7:0]  face_o;
  logic [11:0] total_o;
  int total = 0;
  int bad = 0;
  logic [31:0] tab [0:15];
  int dly = 0;
  bit hang = 1'b0;
  bit pend = 1'b0;
  int cnt = 0;
  int idx = 0;
  int starts = 0;
  int dones = 0;
  int faces[$];
  int cyc;
  bit ok;
  logic err_at;
  logic [11:0] tot_at;

  dice_roll_ctrl dut (
    .clk(clk), .reset(reset), .req_i(req_i), .num_dice_i(num_dice_i), .sides_i(sides_i),
    .busy_o(busy_o), .rng_start_o(rng_start_o), .rng_result_i(rng_result_i),
    .rng_done_i(rng_done_i), .face_o(face_o), .face_valid_o(face_valid_o),
    .total_o(total_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
      rng_done_i <= 1'b0;
    end else begin
      rng_done_i <= 1'b0;
      if (req_i) idx <= 0;
      if (rng_start_o) begin
        pend <= !hang;
        cnt <= dly;
        starts <= starts + 1;
      end else if (pend) begin
        if (cnt == 0) begin
          rng_done_i <= 1'b1;
          rng_result_i <= tab[idx];
          idx <= idx + 1;
          pend <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  always @(posedge clk) if (done_o) dones <= dones + 1;

  a_start: assert property (@(posedge clk) disable iff (!reset) rng_start_o |=> !rng_start_o)
    else $error("FAIL start_width");
  a_done: assert property (@(posedge clk) done_o |-> busy_o)
    else $error("FAIL done_busy");

  task automatic roll(input logic [3:0] n, input logic [7:0] s, input int limit);
    faces = {};
    @(negedge clk);
    req_i = 1'b1;
    num_dice_i = n;
    sides_i = s;
    @(negedge clk);
    req_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (face_valid_o) faces.push_back(int'(face_o));
    end
    ok = done_o;
    err_at = error_o;
    tot_at = total_o;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_o, rng_start_o, face_valid_o, done_o, error_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy_o, rng_start_o, face_valid_o, done_o, error_o});
    end
    total++;
    if (face_o !== 8'd0 || total_o !== 12'd0) begin
      bad++; $display("FAIL reset_data face=%0d total=%0d want=0/0", face_o, total_o);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int s0 = starts;
    dly = 3;
    tab[0] = 32'hABCD_0007; tab[1] = 32'h0000_000C; tab[2] = 32'h0000_FFFF;
    roll(4'd3, 8'd6, 200);
    total++;
    if (!ok || cyc != 71) begin bad++; $display("FAIL basic_latency got=%0d want=71", cyc); end
    total++;
    if (faces.size() != 3 || faces[0] != 2 || faces[1] != 1 || faces[2] != 4) begin
      bad++; $display("FAIL basic_faces got=%p want=2,1,4", faces);
    end
    total++;
    if (tot_at !== 12'd7 || err_at !== 1'b0) begin
      bad++; $display("FAIL basic_total total=%0d err=%b want=7/0", tot_at, err_at);
    end
    total++;
    if (starts - s0 != 3) begin bad++; $display("FAIL basic_starts got=%0d want=3", starts - s0); end
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || total_o !== 12'd7) begin
      bad++; $display("FAIL basic_after busy=%b total=%0d want=0/7", busy_o, total_o);
    end
  endtask

  task automatic test_zero_dice;
    int s0 = starts;
    roll(4'd0, 8'd6, 20);
    total++;
    if (!ok || cyc != 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", cyc); end
    total++;
    if (err_at !== 1'b1 || tot_at !== 12'd0) begin
      bad++; $display("FAIL zero_result err=%b total=%0d want=1/0", err_at, tot_at);
    end
    total++;
    if (starts != s0) begin bad++; $display("FAIL zero_starts got=%0d want=0", starts - s0); end
  endtask

  task automatic test_bad_sides;
    logic [7:0] sv [2];
    sv[0] = 8'd1; sv[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      int s0 = starts;
      roll(4'd4, sv[i], 20);
      total++;
      if (!ok || cyc != 2 || err_at !== 1'b1 || tot_at !== 12'd0 || starts != s0) begin
        bad++;
        $display("FAIL bad_sides s=%0d cyc=%0d err=%b total=%0d starts=%0d want 2/1/0/0",
                 sv[i], cyc, err_at, tot_at, starts - s0);
      end
    end
  endtask

  task automatic test_timeout;
    int s0 = starts;
    hang = 1'b1;
    roll(4'd1, 8'd6, 2000);
    hang = 1'b0;
    total++;
    if (!ok || cyc != 1027) begin bad++; $display("FAIL timeout_latency got=%0d want=1027", cyc); end
    total++;
    if (err_at !== 1'b1 || tot_at !== 12'd0 || faces.size() != 0) begin
      bad++; $display("FAIL timeout_result err=%b total=%0d faces=%0d want=1/0/0", err_at, tot_at, faces.size());
    end
    total++;
    if (starts - s0 != 1) begin bad++; $display("FAIL timeout_starts got=%0d want=1", starts - s0); end
  endtask

  task automatic test_max;
    int n255 = 0;
    dly = 0;
    for (int i = 0; i < 16; i++) tab[i] = 32'h0000_00FE;
    roll(4'd15, 8'd255, 1000);
    foreach (faces[i]) if (faces[i] == 255) n255++;
    total++;
    if (!ok || cyc != 302) begin bad++; $display("FAIL max_latency got=%0d want=302", cyc); end
    total++;
    if (faces.size() != 15 || n255 != 15) begin
      bad++; $display("FAIL max_faces count=%0d at255=%0d want=15/15", faces.size(), n255);
    end
    total++;
    if (tot_at !== 12'hEF1 || err_at !== 1'b0) begin
      bad++; $display("FAIL max_total total=%0d err=%b want=3825/0", tot_at, err_at);
    end
  endtask

  task automatic test_reset_abort;
    int d0;
    dly = 0;
    tab[0] = 32'd1; tab[1] = 32'd2; tab[2] = 32'd3;
    @(negedge clk);
    req_i = 1'b1; num_dice_i = 4'd3; sides_i = 8'd6;
    @(negedge clk);
    req_i = 1'b0;
    repeat (29) @(negedge clk);
    total++;
    if (face_o !== 8'd2 || total_o !== 12'd2 || busy_o !== 1'b1) begin
      bad++; $display("FAIL abort_pre face=%0d total=%0d busy=%b want=2/2/1", face_o, total_o, busy_o);
    end
    d0 = dones;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_o, rng_start_o, face_valid_o, done_o, error_o} !== 5'b0 || face_o !== 8'd0 || total_o !== 12'd0) begin
      bad++; $display("FAIL abort_state ctrl=%b face=%0d total=%0d want=00000/0/0",
                      {busy_o, rng_start_o, face_valid_o, done_o, error_o}, face_o, total_o);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (dones != d0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL abort_nodone dones=%0d busy=%b want=0/0", dones - d0, busy_o);
    end
    tab[0] = 32'd9; tab[1] = 32'd10;
    roll(4'd2, 8'd6, 200);
    total++;
    if (!ok || cyc != 42 || faces.size() != 2 || faces[0] != 4 || faces[1] != 5 || tot_at !== 12'd9 || err_at !== 1'b0) begin
      bad++; $display("FAIL abort_reroll cyc=%0d faces=%p total=%0d err=%b want 42/4,5/9/0", cyc, faces, tot_at, err_at);
    end
  endtask

  task automatic test_busy_req;
    int s0 = starts;
    dly = 0;
    tab[0] = 32'h10;
    faces = {};
    @(negedge clk);
    req_i = 1'b1; num_dice_i = 4'd1; sides_i = 8'd6;
    @(negedge clk);
    cyc = 1;
    num_dice_i = 4'd5; sides_i = 8'd3;
    while (!done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
      req_i = (cyc < 10);
      if (face_valid_o) faces.push_back(int'(face_o));
    end
    req_i = 1'b0;
    total++;
    if (!done_o || cyc != 22 || faces.size() != 1 || faces[0] != 5 || total_o !== 12'd5 || error_o !== 1'b0) begin
      bad++; $display("FAIL busy_req cyc=%0d faces=%p total=%0d err=%b want 22/5/5/0", cyc, faces, total_o, error_o);
    end
    total++;
    if (starts - s0 != 1) begin bad++; $display("FAIL busy_starts got=%0d want=1", starts - s0); end
    repeat (2) @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_drop got=%b want=0", busy_o); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tab[i] = '0;
    test_reset;
    test_basic;
    test_zero_dice;
    test_bad_sides;
    test_timeout;
    test_max;
    test_reset_abort;
    test_busy_req;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
